// File: rtl/hdc_am_search.sv
// Sequential associative-memory search: streams AM rows base..max, Hamming-compares each to the query chunk by chunk, reports the best row.
// Optional top-2 tracking (second_class_o, second_dist_o, margin_o) is enabled by defining HDC_AM_SEARCH_TOP2_EN.
module hdc_am_search #(
  parameter int HV_LENGTH     = 2048,
  parameter int CHUNK_WIDTH   = 512,
  parameter int AM_ADDR_WIDTH = 13,
  parameter int CLASS_WIDTH   = 5,
  parameter int DIST_WIDTH    = $clog2(HV_LENGTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [HV_LENGTH-1:0]     query_i,
  input  logic [AM_ADDR_WIDTH-1:0] base_addr_i,
  input  logic [AM_ADDR_WIDTH-1:0] max_addr_i,
  output logic                     am_ren_o,
  output logic [AM_ADDR_WIDTH-1:0] am_addr_o,
  input  logic [HV_LENGTH-1:0]     am_rdata_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [CLASS_WIDTH-1:0]   best_class_o,
  output logic [DIST_WIDTH-1:0]    best_dist_o,
`ifdef HDC_AM_SEARCH_TOP2_EN
  output logic [CLASS_WIDTH-1:0]   second_class_o,
  output logic [DIST_WIDTH-1:0]    second_dist_o,
  output logic [DIST_WIDTH-1:0]    margin_o,
`endif
  output logic                     range_err_o
);

  localparam int NCHUNK      = HV_LENGTH / CHUNK_WIDTH;
  localparam int CHUNK_IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CHUNK_IDX_W-1:0] LAST_CHUNK = CHUNK_IDX_W'(NCHUNK - 1);
  localparam logic [DIST_WIDTH-1:0]  DIST_ONES  = {DIST_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_CNT  = 3'd3,
    ST_CMP  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  function automatic logic [DIST_WIDTH-1:0] popcount(input logic [CHUNK_WIDTH-1:0] v);
    logic [DIST_WIDTH-1:0] c;
    c = {DIST_WIDTH{1'b0}};
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      c = c + DIST_WIDTH'(v[i]);
    end
    return c;
  endfunction

  state_e                   state_q, state_d;
  logic [HV_LENGTH-1:0]     query_q, query_d;
  logic [HV_LENGTH-1:0]     diff_q, diff_d;
  logic [AM_ADDR_WIDTH-1:0] base_q, base_d;
  logic [AM_ADDR_WIDTH-1:0] max_q, max_d;
  logic [AM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DIST_WIDTH-1:0]    acc_q, acc_d;
  logic [CHUNK_IDX_W-1:0]   chunk_q, chunk_d;
  logic                     ren_q, ren_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [CLASS_WIDTH-1:0]   best_class_q, best_class_d;
  logic [DIST_WIDTH-1:0]    best_dist_q, best_dist_d;
  logic                     range_err_q, range_err_d;
  logic [AM_ADDR_WIDTH-1:0] offset_s;
`ifdef HDC_AM_SEARCH_TOP2_EN
  logic [CLASS_WIDTH-1:0]   second_class_q, second_class_d;
  logic [DIST_WIDTH-1:0]    second_dist_q, second_dist_d;
  logic [DIST_WIDTH-1:0]    margin_q, margin_d;
`endif

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d      = state_q;
    query_d      = query_q;
    diff_d       = diff_q;
    base_d       = base_q;
    max_d        = max_q;
    addr_d       = addr_q;
    acc_d        = acc_q;
    chunk_d      = chunk_q;
    best_class_d = best_class_q;
    best_dist_d  = best_dist_q;
    range_err_d  = range_err_q;
    offset_s     = addr_q - base_q;
`ifdef HDC_AM_SEARCH_TOP2_EN
    second_class_d = second_class_q;
    second_dist_d  = second_dist_q;
    margin_d       = margin_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          query_d      = query_i;
          base_d       = base_addr_i;
          max_d        = max_addr_i;
          addr_d       = base_addr_i;
          best_dist_d  = DIST_ONES;
          best_class_d = {CLASS_WIDTH{1'b0}};
`ifdef HDC_AM_SEARCH_TOP2_EN
          second_dist_d  = DIST_ONES;
          second_class_d = {CLASS_WIDTH{1'b0}};
          margin_d       = {DIST_WIDTH{1'b0}};
`endif
          if (max_addr_i < base_addr_i) begin
            range_err_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            range_err_d = 1'b0;
            state_d     = ST_REQ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        diff_d  = am_rdata_i ^ query_q;
        acc_d   = {DIST_WIDTH{1'b0}};
        chunk_d = {CHUNK_IDX_W{1'b0}};
        state_d = ST_CNT;
      end
      ST_CNT: begin
        // diff is shifted down so the active chunk always sits in the low bits
        acc_d   = acc_q + popcount(diff_q[CHUNK_WIDTH-1:0]);
        diff_d  = diff_q >> CHUNK_WIDTH;
        chunk_d = chunk_q + CHUNK_IDX_W'(1);
        if (chunk_q == LAST_CHUNK) begin
          state_d = ST_CMP;
        end else begin
          state_d = ST_CNT;
        end
      end
      ST_CMP: begin
        if (acc_q < best_dist_q) begin
`ifdef HDC_AM_SEARCH_TOP2_EN
          second_dist_d  = best_dist_q;
          second_class_d = best_class_q;
`endif
          best_dist_d  = acc_q;
          best_class_d = CLASS_WIDTH'(offset_s);
`ifdef HDC_AM_SEARCH_TOP2_EN
        end else if (acc_q < second_dist_q) begin
          second_dist_d  = acc_q;
          second_class_d = CLASS_WIDTH'(offset_s);
`endif
        end else begin
          best_dist_d = best_dist_q;
        end
`ifdef HDC_AM_SEARCH_TOP2_EN
        margin_d = (second_dist_d == DIST_ONES) ? DIST_ONES : (second_dist_d - best_dist_d);
`endif
        if (addr_q == max_q) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + AM_ADDR_WIDTH'(1);
          state_d = ST_REQ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ren_d  = (state_d == ST_REQ);
    busy_d = (state_q != ST_IDLE);
    done_d = (state_q == ST_DONE);

    // Abort wins over everything and rolls results back to their start-cleared values.
    if (abort_i && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      ren_d        = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      best_dist_d  = DIST_ONES;
      best_class_d = {CLASS_WIDTH{1'b0}};
      range_err_d  = 1'b0;
`ifdef HDC_AM_SEARCH_TOP2_EN
      second_dist_d  = DIST_ONES;
      second_class_d = {CLASS_WIDTH{1'b0}};
      margin_d       = {DIST_WIDTH{1'b0}};
`endif
    end else begin
      busy_d = busy_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      query_q      <= {HV_LENGTH{1'b0}};
      diff_q       <= {HV_LENGTH{1'b0}};
      base_q       <= {AM_ADDR_WIDTH{1'b0}};
      max_q        <= {AM_ADDR_WIDTH{1'b0}};
      addr_q       <= {AM_ADDR_WIDTH{1'b0}};
      acc_q        <= {DIST_WIDTH{1'b0}};
      chunk_q      <= {CHUNK_IDX_W{1'b0}};
      ren_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      best_class_q <= {CLASS_WIDTH{1'b0}};
      best_dist_q  <= DIST_ONES;
      range_err_q  <= 1'b0;
`ifdef HDC_AM_SEARCH_TOP2_EN
      second_class_q <= {CLASS_WIDTH{1'b0}};
      second_dist_q  <= DIST_ONES;
      margin_q       <= {DIST_WIDTH{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      query_q      <= query_d;
      diff_q       <= diff_d;
      base_q       <= base_d;
      max_q        <= max_d;
      addr_q       <= addr_d;
      acc_q        <= acc_d;
      chunk_q      <= chunk_d;
      ren_q        <= ren_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      best_class_q <= best_class_d;
      best_dist_q  <= best_dist_d;
      range_err_q  <= range_err_d;
`ifdef HDC_AM_SEARCH_TOP2_EN
      second_class_q <= second_class_d;
      second_dist_q  <= second_dist_d;
      margin_q       <= margin_d;
`endif
    end
  end

  assign am_ren_o     = ren_q;
  assign am_addr_o    = addr_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign best_class_o = best_class_q;
  assign best_dist_o  = best_dist_q;
  assign range_err_o  = range_err_q;
`ifdef HDC_AM_SEARCH_TOP2_EN
  assign second_class_o = second_class_q;
  assign second_dist_o  = second_dist_q;
  assign margin_o       = margin_q;
`endif

endmodule

// File: tb/tb_hdc_am_search.sv
// Self-checking bench for hdc_am_search: table vectors, hand-written corner sequences and randomized searches vs a reference model.
module tb_hdc_am_search;

  localparam int HV = 2048;

  logic            clk = 1'b0;
  logic            rst;
  logic            start, start1, abort;
  logic [HV-1:0]   query;
  logic [12:0]     base_addr, max_addr;
  logic            am_ren, am_ren1;
  logic [12:0]     am_addr, am_addr1;
  logic [HV-1:0]   am_rdata, am_rdata1;
  logic            busy, done, busy1, done1;
  logic [4:0]      best_class, best_class1;
  logic [11:0]     best_dist, best_dist1;
  logic            range_err, range_err1;
`ifdef HDC_AM_SEARCH_TOP2_EN
  logic [4:0]      second_class, second_class1;
  logic [11:0]     second_dist, second_dist1, margin, margin1;
`endif

  logic [HV-1:0]   mem [16];
  logic [HV-1:0]   q_ref;
  int              checks = 0;
  int              errors = 0;
  int              ren_cnt = 0;
  int              done_cnt = 0;

  always #5 clk = ~clk;

  hdc_am_search u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .query_i(query),
    .base_addr_i(base_addr), .max_addr_i(max_addr), .am_ren_o(am_ren), .am_addr_o(am_addr),
    .am_rdata_i(am_rdata), .busy_o(busy), .done_o(done), .best_class_o(best_class),
    .best_dist_o(best_dist),
`ifdef HDC_AM_SEARCH_TOP2_EN
    .second_class_o(second_class), .second_dist_o(second_dist), .margin_o(margin),
`endif
    .range_err_o(range_err)
  );

  hdc_am_search #(.CHUNK_WIDTH(2048)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .abort_i(1'b0), .query_i(query),
    .base_addr_i(base_addr), .max_addr_i(max_addr), .am_ren_o(am_ren1), .am_addr_o(am_addr1),
    .am_rdata_i(am_rdata1), .busy_o(busy1), .done_o(done1), .best_class_o(best_class1),
    .best_dist_o(best_dist1),
`ifdef HDC_AM_SEARCH_TOP2_EN
    .second_class_o(second_class1), .second_dist_o(second_dist1), .margin_o(margin1),
`endif
    .range_err_o(range_err1)
  );

  // AM model: one-cycle read latency
  always @(posedge clk) begin
    if (am_ren)  am_rdata  <= mem[am_addr[3:0]];
    if (am_ren1) am_rdata1 <= mem[am_addr1[3:0]];
  end

  always @(negedge clk) begin
    if (am_ren) ren_cnt++;
    if (done) done_cnt++;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [HV-1:0] mk_row(input int d);
    logic [HV-1:0] v;
    v = q_ref;
    for (int i = 0; i < d; i++) v[i] = ~v[i];
    return v;
  endfunction

  task automatic check_reset_vals(input string nm);
    check({nm, "_ren"},   am_ren, 1'b0);
    check({nm, "_addr"},  am_addr, 13'd0);
    check({nm, "_busy"},  busy, 1'b0);
    check({nm, "_done"},  done, 1'b0);
    check({nm, "_class"}, best_class, 5'd0);
    check({nm, "_dist"},  best_dist, 12'hFFF);
    check({nm, "_err"},   range_err, 1'b0);
  endtask

  task automatic run_search(input logic [12:0] b, input logic [12:0] m, input logic [4:0] ec,
                            input logic [11:0] ed, input logic ee, input int ecyc, input int eren,
                            input string nm);
    int cyc;
    bit seen;
    @(negedge clk);
    base_addr = b; max_addr = m; start = 1'b1; ren_cnt = 0;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 400) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) check({nm, "_busy_rise"}, busy, 1'b1);
      if (done) seen = 1'b1;
    end
    check({nm, "_done_seen"}, seen, 1'b1);
    check({nm, "_latency"}, cyc, ecyc);
    check({nm, "_class"}, best_class, ec);
    check({nm, "_dist"}, best_dist, ed);
    check({nm, "_err"}, range_err, ee);
    check({nm, "_ren_pulses"}, ren_cnt, eren);
    @(negedge clk);
    check({nm, "_busy_fall"}, busy, 1'b0);
    check({nm, "_done_pulse"}, done, 1'b0);
  endtask

  typedef struct {
    logic [12:0] b;
    logic [12:0] m;
    logic [4:0]  c;
    logic [11:0] d;
    logic        e;
    int          cyc;
    int          ren;
  } vec_t;

  vec_t tbl[8];
  int   dists[16] = '{1000, 900, 100, 100, 0, 1000, 2048, 5, 5, 700, 2000, 1, 1, 1500, 3, 2047};

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0; abort = 1'b0;
    base_addr = 13'd0; max_addr = 13'd0;
    for (int w = 0; w < HV / 32; w++) q_ref[w*32 +: 32] = $urandom();
    query = q_ref;
    for (int r = 0; r < 16; r++) mem[r] = mk_row(dists[r]);

    tbl[0] = '{13'd1,  13'd7,  5'd3, 12'd0,    1'b0, 50,  7};
    tbl[1] = '{13'd2,  13'd3,  5'd0, 12'd100,  1'b0, 15,  2};
    tbl[2] = '{13'd6,  13'd6,  5'd0, 12'd2048, 1'b0, 8,   1};
    tbl[3] = '{13'd7,  13'd12, 5'd4, 12'd1,    1'b0, 43,  6};
    tbl[4] = '{13'd6,  13'd2,  5'd0, 12'hFFF,  1'b1, 1,   0};
    tbl[5] = '{13'd13, 13'd15, 5'd1, 12'd3,    1'b0, 22,  3};
    tbl[6] = '{13'd0,  13'd15, 5'd4, 12'd0,    1'b0, 113, 16};
    tbl[7] = '{13'd10, 13'd9,  5'd0, 12'hFFF,  1'b1, 1,   0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_search(tbl[i].b, tbl[i].m, tbl[i].c, tbl[i].d, tbl[i].e, tbl[i].cyc, tbl[i].ren, $sformatf("tbl%0d", i));

    // single-chunk instance against the fully inverted row
    begin
      int cyc;
      bit seen;
      @(negedge clk);
      base_addr = 13'd6; max_addr = 13'd6; start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 50) begin
        @(posedge clk); cyc++;
        @(negedge clk);
        if (done1) seen = 1'b1;
      end
      check("nchunk1_done_seen", seen, 1'b1);
      check("nchunk1_latency", cyc, 5);
      check("nchunk1_dist", best_dist1, 12'd2048);
      check("nchunk1_class", best_class1, 5'd0);
    end

    // tie between rows 2 and 3, everything else far away
    mem[4] = mk_row(1000);
    mem[5] = mk_row(1000);
    run_search(13'd2, 13'd5, 5'd0, 12'd100, 1'b0, 29, 4, "tie");
`ifdef HDC_AM_SEARCH_TOP2_EN
    check("tie_second_class", second_class, 5'd1);
    check("tie_margin", margin, 12'd0);
`endif

    // abort in CNT of the third class
    begin
      int dc;
      @(negedge clk);
      base_addr = 13'd0; max_addr = 13'd5; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (17) @(posedge clk);
      @(negedge clk);
      check("abort_pre_busy", busy, 1'b1);
      check("abort_pre_dist", best_dist, 12'd900);
      dc = done_cnt;
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 1'b0);
      check("abort_ren", am_ren, 1'b0);
      check("abort_dist", best_dist, 12'hFFF);
      check("abort_class", best_class, 5'd0);
      repeat (20) @(negedge clk);
      check("abort_no_done", done_cnt, dc);
      run_search(13'd0, 13'd0, 5'd0, 12'd1000, 1'b0, 8, 1, "post_abort");
    end

    // start re-pulsed while busy, then reset mid-search
    begin
      int dc;
      dc = done_cnt;
      @(negedge clk);
      base_addr = 13'd1; max_addr = 13'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      base_addr = 13'd6; max_addr = 13'd2; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (15) @(posedge clk);
      @(negedge clk);
      check("restart_busy", busy, 1'b1);
      check("restart_addr", am_addr, 13'd3);
      check("restart_err", range_err, 1'b0);
      check("restart_no_done", done_cnt, dc);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_vals("midreset");
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("midreset_no_done", done_cnt, dc);
    end

    // randomized searches vs reference model
    for (int it = 0; it < 12; it++) begin
      logic [12:0] b, m;
      logic [4:0]  ec;
      logic [11:0] ed;
      int          best, n;
      for (int r = 0; r < 16; r++) begin
        logic [HV-1:0] v;
        for (int w = 0; w < HV / 32; w++) v[w*32 +: 32] = $urandom() & $urandom() & $urandom();
        mem[r] = q_ref ^ v;
        if (r > 0 && $urandom_range(0, 3) == 0) mem[r] = mem[$urandom_range(0, r - 1)];
      end
      b = 13'($urandom_range(0, 15));
      m = 13'($urandom_range(0, 15));
      if (m < b) begin
        run_search(b, m, 5'd0, 12'hFFF, 1'b1, 1, 0, $sformatf("rnd%0d", it));
      end else begin
        best = 4096; ec = 5'd0; n = 0;
        for (int a = int'(b); a <= int'(m); a++) begin
          int d;
          d = $countones(q_ref ^ mem[a]);
          if (d < best) begin
            best = d;
            ec = 5'(a - int'(b));
          end
          n++;
        end
        ed = 12'(best);
        run_search(b, m, ec, ed, 1'b0, n * 7 + 1, n, $sformatf("rnd%0d", it));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hdc_am_search.md
# hdc_am_search

Sequential associative-memory (AM) search engine for the HDC accelerator. It takes one encoded query hypervector and streams the class rows stored between a programmable base and max AM address. For each row it computes the Hamming distance chunk by chunk and reports the best-matching class index and its distance. It sits between the encoder output and the status/CSR path, replacing the single-purpose fixed-width similarity compare with a parametrised, multi-cycle search over any class range.

## Interface
- HV_LENGTH, 2048: hypervector width in bits.
- CHUNK_WIDTH, 512: bits popcounted per cycle. Must divide HV_LENGTH. NCHUNK = HV_LENGTH/CHUNK_WIDTH.
- AM_ADDR_WIDTH, 13: AM row address width.
- CLASS_WIDTH, 5: width of the reported class index.
- DIST_WIDTH, $clog2(HV_LENGTH+1): distance width, 12 at default.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  start a search. Sampled only in IDLE.
- abort_i  in  1  cancel a running search. Returns to IDLE with no done pulse.
- query_i  in  HV_LENGTH  query HV. Latched on accepted start.
- base_addr_i  in  AM_ADDR_WIDTH  first class row. Latched on start.
- max_addr_i  in  AM_ADDR_WIDTH  last class row, inclusive. Latched on start.
- am_ren_o  out  1  AM read strobe.
- am_addr_o  out  AM_ADDR_WIDTH  AM row address.
- am_rdata_i  in  HV_LENGTH  AM read data. Valid exactly one cycle after am_ren_o.
- busy_o  out  1  search in progress.
- done_o  out  1  one-cycle pulse when results are valid.
- best_class_o  out  CLASS_WIDTH  winning row minus base_addr, truncated to CLASS_WIDTH.
- best_dist_o  out  DIST_WIDTH  Hamming distance of the winning row.
- range_err_o  out  1  set with done_o when max_addr < base_addr.

## Operation
- States: IDLE, REQ, WAIT, CNT, CMP, DONE.
- IDLE, start_i=1:
  - latch query, base, max; addr<=base; best_dist<=all-ones; best_class<=0; range_err<=0.
  - If max<base, go to DONE with range_err<=1. Otherwise go to REQ.
- REQ: am_ren_o=1, am_addr_o=addr, for one cycle → WAIT.
- WAIT: diff<=am_rdata_i ^ query; acc<=0; chunk<=0 → CNT.
- CNT: acc += popcount(diff[chunk*CHUNK_WIDTH +: CHUNK_WIDTH]); chunk++. After chunk NCHUNK-1 is added → CMP.
- CMP:
  - If acc < best_dist (strict), update best_dist<=acc and best_class<=addr-base. Ties keep the lower index.
  - If addr==max → DONE. Otherwise addr<=addr+1 → REQ.
- DONE: done_o=1 → IDLE.
- Results hold until the next accepted start, which clears them.
- busy_o=1 in every state except IDLE.
- start_i while busy is ignored.
- abort_i has priority over start_i and over every state transition. It forces IDLE, drives am_ren_o low the same cycle, and leaves results at their cleared start values.
- Address arithmetic is AM_ADDR_WIDTH wide. If max is the all-ones address, the search terminates on addr==max, so the address never wraps.
- acc and best_dist are DIST_WIDTH wide and cannot overflow, since the maximum is HV_LENGTH.

## Timing
- Reset values: am_ren_o=0, am_addr_o=0, busy_o=0, done_o=0, best_class_o=0, best_dist_o=all-ones, range_err_o=0. State=IDLE.
- Reset mid-search returns to these values next edge; no done pulse.
- Cycles per class: NCHUNK+3 (REQ, WAIT, NCHUNK×CNT, CMP). This is 7 at default.
- For N=max-base+1 classes, done_o is asserted N*(NCHUNK+3)+1 cycles after the start edge.
- A range error pulses done_o 1 cycle after start.
- busy_o rises the cycle after start is accepted and falls the cycle after done_o.
- A new start is accepted the cycle after done_o.
- All outputs are registered.

## Configuration
- Macro HDC_AM_SEARCH_TOP2_EN.
- When defined, the block adds these outputs:
  - second_class_o (CLASS_WIDTH)
  - second_dist_o (DIST_WIDTH)
  - margin_o (DIST_WIDTH) = second_dist-best_dist
- Top-2 tracking in CMP:
  - If acc<best: the old best demotes to second.
  - Else if acc<second: second updates.
- With a single class, second_dist stays all-ones and margin_o saturates to all-ones.
- Reset values: second_class_o=0, second_dist_o=all-ones, margin_o=0.
- When undefined, these ports and registers do not exist and timing is identical.

## Test plan
- Rows 1..7 preloaded, query equals row 4, defaults: start with base=1, max=7 → done_o at cycle 50, best_class_o=3, best_dist_o=0, range_err_o=0.
- Rows 2 and 3 both at distance 100, all others at 1000, base=2, max=5: → best_class_o=0 (tie keeps lower), best_dist_o=100. With TOP2_EN: second_class_o=1, margin_o=0.
- base=6, max=2 → done_o 1 cycle after start, range_err_o=1, no am_ren_o pulses.
- abort_i asserted in CNT of the 3rd class → busy_o low next cycle; no done_o; next start with base=max=0 completes in 8 cycles.
- start_i re-pulsed while busy, then rst_i mid-search: the second start is ignored; reset restores all outputs to reset values, with best_dist_o=12'hFFF.
- CHUNK_WIDTH=2048 (NCHUNK=1), query inverted versus a single row → done_o at cycle 5, best_dist_o=2048.
